// File: rtl/mouse_pkg.sv
// mouse_pkg: shared widths, FSM encoding and default display geometry
// for the PS/2 cursor tracker.
package mouse_pkg;
   localparam int DELTA_W    = 9;
   localparam int POS_W      = 10;
   localparam int SUM_W      = 12;
   localparam int H_MAX_DEF  = 639;
   localparam int V_MAX_DEF  = 479;
   localparam int X_INIT_DEF = 320;
   localparam int Y_INIT_DEF = 240;

   typedef enum logic [1:0] {S_IDLE, S_SUM, S_LIMIT} state_t;

   function automatic logic signed [SUM_W-1:0] sext(input logic [DELTA_W-1:0] d);
      return {{(SUM_W-DELTA_W){d[DELTA_W-1]}}, d};
   endfunction
endpackage

// File: rtl/mouse_axis_limit.sv
// mouse_axis_limit: folds one signed axis sum into [0, MAX].
// Clamps by default; wraps around the screen edge when MOUSE_WRAP_EN is defined.
module mouse_axis_limit
   import mouse_pkg::*;
#(
   parameter int MAX = H_MAX_DEF
) (
   input  logic signed [SUM_W-1:0] i_sum,
   output logic        [POS_W-1:0] o_pos
);
   localparam logic signed [SUM_W-1:0] L_MAX = SUM_W'(MAX);
`ifdef MOUSE_WRAP_EN
   // A single delta never exceeds MAX+1, so one correction lands in range.
   localparam logic signed [SUM_W-1:0] L_SPAN = SUM_W'(MAX + 1);
   always_comb
      o_pos = i_sum[SUM_W-1]  ? POS_W'(i_sum + L_SPAN) :
              (i_sum > L_MAX) ? POS_W'(i_sum - L_SPAN) : i_sum[POS_W-1:0];
`else
   always_comb
      o_pos = i_sum[SUM_W-1]  ? '0 :
              (i_sum > L_MAX) ? POS_W'(MAX) : i_sum[POS_W-1:0];
`endif
endmodule

// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker: integrates PS/2 movement packets into a bounded cursor
// position with button press pulses. MOUSE_WRAP_EN selects wrap instead of clamp.
module mouse_cursor_tracker
   import mouse_pkg::*;
#(
   parameter int H_MAX  = H_MAX_DEF,
   parameter int V_MAX  = V_MAX_DEF,
   parameter int X_INIT = X_INIT_DEF,
   parameter int Y_INIT = Y_INIT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mouse_done,
   input  logic [DELTA_W-1:0] xm,
   input  logic [DELTA_W-1:0] ym,
   input  logic [2:0]         button,
   output logic [POS_W-1:0]   x_pos,
   output logic [POS_W-1:0]   y_pos,
   output logic [2:0]         btn,
   output logic [2:0]         btn_press,
   output logic               pos_valid,
   output logic               overrun
);
   state_t                   r_state;
   logic [DELTA_W-1:0]       r_wx, r_wy, r_px, r_py;
   logic [2:0]               r_wb, r_pb;
   logic                     r_pend;
   logic signed [SUM_W-1:0]  r_nx, r_ny;
   logic [POS_W-1:0]         w_lx, w_ly;

   mouse_axis_limit #(.MAX(H_MAX)) u_lim_x (.i_sum(r_nx), .o_pos(w_lx));
   mouse_axis_limit #(.MAX(V_MAX)) u_lim_y (.i_sum(r_ny), .o_pos(w_ly));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_wx      <= '0;
         r_wy      <= '0;
         r_wb      <= '0;
         r_px      <= '0;
         r_py      <= '0;
         r_pb      <= '0;
         r_pend    <= 1'b0;
         r_nx      <= '0;
         r_ny      <= '0;
         x_pos     <= POS_W'(X_INIT);
         y_pos     <= POS_W'(Y_INIT);
         btn       <= '0;
         btn_press <= '0;
         pos_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         pos_valid <= 1'b0;
         btn_press <= '0;
         case (r_state)
            S_IDLE: if (mouse_done) begin
               r_wx    <= xm;
               r_wy    <= ym;
               r_wb    <= button;
               r_state <= S_SUM;
            end
            S_SUM: begin
               r_nx    <= $signed({{(SUM_W-POS_W){1'b0}}, x_pos}) + sext(r_wx);
               r_ny    <= $signed({{(SUM_W-POS_W){1'b0}}, y_pos}) - sext(r_wy);
               r_state <= S_LIMIT;
               if (mouse_done) begin
                  r_px    <= xm;
                  r_py    <= ym;
                  r_pb    <= button;
                  r_pend  <= 1'b1;
                  overrun <= overrun | r_pend;
               end
            end
            S_LIMIT: begin
               x_pos     <= w_lx;
               y_pos     <= w_ly;
               btn       <= r_wb;
               btn_press <= r_wb & ~btn;
               pos_valid <= 1'b1;
               r_pend    <= 1'b0;
               // A packet arriving now supersedes the buffered one and goes straight to work.
               if (mouse_done || r_pend) begin
                  r_wx    <= mouse_done ? xm : r_px;
                  r_wy    <= mouse_done ? ym : r_py;
                  r_wb    <= mouse_done ? button : r_pb;
                  r_state <= S_SUM;
               end else
                  r_state <= S_IDLE;
               if (mouse_done && r_pend) overrun <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// tb_mouse_cursor_tracker: directed spec cases plus randomized packet traffic
// checked against a packet-level reference model (honours MOUSE_WRAP_EN).
module tb_mouse_cursor_tracker;
   logic       clk = 1'b0, reset = 1'b0, mouse_done = 1'b0;
   logic [8:0] xm = '0, ym = '0;
   logic [2:0] button = '0;
   logic [9:0] x_pos, y_pos;
   logic [2:0] btn, btn_press;
   logic       pos_valid, overrun;

   int n_chk = 0, n_pass = 0, pv_count = 0;
   int mx, my, e = 0, fl_e;
   logic [2:0] mb, exp_bp, fl_b, pd_b;
   logic [8:0] fl_x, fl_y, pd_x, pd_y;
   logic exp_pv, exp_ov, fl_v, pd_v;

   always #5 clk = ~clk;

   mouse_cursor_tracker dut (
      .clk(clk), .reset(reset), .mouse_done(mouse_done), .xm(xm), .ym(ym),
      .button(button), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
      .btn_press(btn_press), .pos_valid(pos_valid), .overrun(overrun)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   function automatic int lim(input int v, input int m);
`ifdef MOUSE_WRAP_EN
      return v < 0 ? v + m + 1 : v > m ? v - m - 1 : v;
`else
      return v < 0 ? 0 : v > m ? m : v;
`endif
   endfunction

   task automatic model_reset();
      mx = 320; my = 240; mb = '0; exp_bp = '0;
      exp_pv = 1'b0; exp_ov = 1'b0; fl_v = 1'b0; pd_v = 1'b0;
   endtask

   // Packet-level model: a packet takes two edges to land, one may wait behind it.
   task automatic model_edge(input logic d, input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
      e++;
      exp_pv = 1'b0; exp_bp = '0;
      if (fl_v && e == fl_e + 2) begin
         mx = lim(mx + int'($signed(fl_x)), 639);
         my = lim(my - int'($signed(fl_y)), 479);
         exp_bp = fl_b & ~mb;
         mb = fl_b;
         exp_pv = 1'b1;
         fl_v = 1'b0;
      end
      if (!fl_v) begin
         if (d) begin
            if (pd_v) exp_ov = 1'b1;
            fl_x = x; fl_y = y; fl_b = b; fl_v = 1'b1; fl_e = e; pd_v = 1'b0;
         end else if (pd_v) begin
            fl_x = pd_x; fl_y = pd_y; fl_b = pd_b; fl_v = 1'b1; fl_e = e; pd_v = 1'b0;
         end
      end else if (d) begin
         if (pd_v) exp_ov = 1'b1;
         pd_x = x; pd_y = y; pd_b = b; pd_v = 1'b1;
      end
   endtask

   task automatic compare();
      chk("pos_valid", int'(pos_valid), int'(exp_pv));
      chk("btn_press", int'(btn_press), int'(exp_bp));
      chk("x_pos", int'(x_pos), mx);
      chk("y_pos", int'(y_pos), my);
      chk("btn", int'(btn), int'(mb));
      chk("overrun", int'(overrun), int'(exp_ov));
      if (pos_valid) pv_count++;
   endtask

   task automatic step(input logic d, input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
      mouse_done = d; xm = x; ym = y; button = b;
      @(posedge clk);
      model_edge(d, x, y, b);
      #1;
      compare();
      mouse_done = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 9'h000, 9'h000, 3'b000);
   endtask

   task automatic pkt(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
      step(1'b1, x, y, b);
      idle(2);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      model_reset();
      compare();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset();
      idle(2);
      chk("rst_x", int'(x_pos), 320);
      chk("rst_y", int'(y_pos), 240);
      chk("rst_pv", int'(pos_valid), 0);
      chk("rst_ov", int'(overrun), 0);

      pkt(9'h00A, 9'h005, 3'b000);
      chk("basic_x", int'(x_pos), 330);
      chk("basic_y", int'(y_pos), 235);
      chk("basic_pv", int'(pos_valid), 1);
      idle(1);
      chk("basic_pv_drop", int'(pos_valid), 0);

      pkt(9'h0FF, 9'h110, 3'b000);
      pkt(9'h032, 9'h000, 3'b000);
      chk("edge_x", int'(x_pos), 635);
      chk("edge_y", int'(y_pos), 475);
      pkt(9'h014, 9'h1F6, 3'b000);
`ifdef MOUSE_WRAP_EN
      chk("bound_x", int'(x_pos), 15);
      chk("bound_y", int'(y_pos), 5);
`else
      chk("bound_x", int'(x_pos), 639);
      chk("bound_y", int'(y_pos), 479);
`endif

      do_reset();
      pkt(9'h124, 9'h000, 3'b000);
      chk("left_x", int'(x_pos), 100);
      pkt(9'h100, 9'h000, 3'b000);
`ifdef MOUSE_WRAP_EN
      chk("neg256_x", int'(x_pos), 484);
`else
      chk("neg256_x", int'(x_pos), 0);
`endif

      do_reset();
      pkt(9'h000, 9'h000, 3'b001);
      chk("press1", int'(btn_press), 1);
      pkt(9'h000, 9'h000, 3'b011);
      chk("press2", int'(btn_press), 2);
      pkt(9'h000, 9'h000, 3'b010);
      chk("press3", int'(btn_press), 0);
      chk("btn_follow", int'(btn), 2);

      do_reset();
      pv_count = 0;
      step(1'b1, 9'h001, 9'h000, 3'b000);
      step(1'b1, 9'h002, 9'h000, 3'b000);
      step(1'b1, 9'h004, 9'h000, 3'b000);
      idle(5);
      chk("ovr_flag", int'(overrun), 1);
      chk("ovr_x", int'(x_pos), 325);
      chk("ovr_pulses", pv_count, 2);

      step(1'b1, 9'h050, 9'h050, 3'b111);
      step(1'b0, 9'h000, 9'h000, 3'b000);
      do_reset();
      pv_count = 0;
      idle(4);
      chk("abort_x", int'(x_pos), 320);
      chk("abort_ov", int'(overrun), 0);
      chk("abort_pulses", pv_count, 0);

      for (int i = 0; i < 600; i++) begin
         if (i == 300) do_reset();
         step($urandom_range(0, 99) < 45, 9'($urandom), 9'($urandom), 3'($urandom));
      end
      idle(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mouse_cursor_tracker.md
# mouse_cursor_tracker

Downstream consumer of the PS/2 mouse packet decoder. On each `mouse_done` pulse it accumulates the decoded 9-bit two's-complement X/Y movement deltas into an absolute screen-space cursor position, bounded to a configurable display area. It also registers button state and emits one-cycle press pulses. Outputs feed the display/pixel-generation logic directly.

## Interface
Parameters:
- `H_MAX`, 639: largest legal X coordinate. Must satisfy 255 ≤ `H_MAX` ≤ 1023.
- `V_MAX`, 479: largest legal Y coordinate. Must satisfy 255 ≤ `V_MAX` ≤ 1023.
- `X_INIT`, 320: X position after reset.
- `Y_INIT`, 240: Y position after reset.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mouse_done` in 1: one-cycle strobe; `xm`, `ym`, `button` are valid in the same cycle.
- `xm` in 9: X delta, two's complement, bit 8 = sign, positive = right.
- `ym` in 9: Y delta, two's complement, positive = up (PS/2 convention).
- `button` in 3: {middle, right, left}, 1 = pressed.
- `x_pos` out 10: cursor X.
- `y_pos` out 10: cursor Y, 0 = top of screen.
- `btn` out 3: registered button state.
- `btn_press` out 3: one-cycle pulse per button on a 0→1 transition.
- `pos_valid` out 1: one-cycle pulse when `x_pos`, `y_pos` and `btn` update.
- `overrun` out 1: sticky flag; a packet was lost.

## Operation
- Reset values: `x_pos`=`X_INIT`, `y_pos`=`Y_INIT`, `btn`=0, `btn_press`=0, `pos_valid`=0, `overrun`=0, state IDLE, pending buffer empty.
- FSM states: IDLE, SUM, LIMIT.
  - IDLE: on `mouse_done`, capture `xm`/`ym`/`button` into the work registers and go to SUM.
  - SUM: `nx = x_pos + sext(xm)`, `ny = y_pos - sext(ym)`, both 12-bit signed. Go to LIMIT.
  - LIMIT: apply the limit rule per axis. Register `x_pos`, `y_pos`, `btn` = work button. Set `btn_press = work_button & ~btn` (old `btn`). Pulse `pos_valid`. If the pending buffer is full, load it into the work registers, clear it, and go to SUM. Otherwise go to IDLE.
- Limit rule (default, clamp): values < 0 become 0; values > MAX become MAX.
- Pending buffer: 1 entry.
  - `mouse_done` in SUM or LIMIT writes the pending buffer.
  - If the buffer is already full, the new packet overwrites it and `overrun` is set.
  - `mouse_done` in LIMIT while the buffer is full is an overwrite.
- `overrun` clears only on reset.
- Reset asserted mid-operation aborts any in-flight packet and discards pending data.

## Timing
- `mouse_done` sampled at edge T: work registers load at T, sum registers at T+1, outputs and `pos_valid` at T+2.
- `pos_valid` and `btn_press` are high for exactly the cycle after edge T+2.
- Sustained throughput: one packet per 2 cycles via the pending path. SUM always uses the already-updated `x_pos`/`y_pos`.
- `btn_press` is 0 in every cycle where `pos_valid` is 0.

## Configuration
- `MOUSE_WRAP_EN` defined: the limit rule wraps instead of clamping.
  - nx < 0 becomes nx + `H_MAX` + 1; nx > `H_MAX` becomes nx − (`H_MAX` + 1). Same for Y with `V_MAX`.
  - One correction is always sufficient because |delta| ≤ 256 ≤ MAX + 1.
- Undefined: clamp behaviour as in Operation.

## Structure
- Package `mouse_pkg`: FSM state encoding, `DELTA_W`=9, `POS_W`=10, `SUM_W`=12, default `H_MAX`/`V_MAX`/`X_INIT`/`Y_INIT` constants.
- Sub-module `mouse_axis_limit`: combinational clamp/wrap of one 12-bit signed sum to [0, MAX]. Instantiated twice (X, Y); the `MOUSE_WRAP_EN` branch lives inside it.

## Test plan
- Reset, no traffic → `x_pos`=320, `y_pos`=240, `btn`=0, `pos_valid`=0, `overrun`=0.
- `mouse_done` with `xm`=9'h00A, `ym`=9'h005 → two edges later `x_pos`=330, `y_pos`=235, `pos_valid` high for one cycle.
- From (635, 475), `xm`=9'h014, `ym`=9'h1F6 → clamp build gives (639, 479); wrap build gives (15, 5).
- From `x_pos`=100, `xm`=9'h100 (−256) → `x_pos`=0 (clamp); `x_pos`=484 (wrap).
- `button`=3'b001, then 3'b011, then 3'b010 on successive packets → `btn_press` = 001, 010, 000; `btn` follows `button`.
- `mouse_done` on three consecutive cycles with `xm` = +1, +2, +4 from x=320:
  - First packet processes; third overwrites second in pending; `overrun`=1.
  - Final `x_pos`=325 after two `pos_valid` pulses.
